// File: rtl/key_filter.sv
// Debounce and event extraction for one active-low push-button.
// Emits clean press/release/long-press pulses and a debounced level.
module key_filter #(
  parameter int DEB_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_flag,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  localparam int CW = $clog2(DEB_MAX);
  localparam int HW = $clog2(LONG_MAX + 1);

  localparam logic [CW-1:0] CNT_END  = CW'(DEB_MAX - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(LONG_MAX);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILTER,
    DOWN,
    RELEASE_FILTER
  } state_t;

  state_t        r_state;
  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic [HW-1:0] r_hold;

  // Two-flop synchroniser, idles at the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= key_in;
      r_s2 <= r_s1;
    end
  end

  // Debounce FSM with registered pulse and level outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      key_flag    <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_s2) begin
            r_state <= PRESS_FILTER;
            r_cnt   <= '0;
          end
        end
        PRESS_FILTER: begin
          if (r_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_END) begin
            r_state   <= DOWN;
            r_hold    <= '0;
            key_flag  <= 1'b1;
            key_state <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DOWN: begin
          // Saturating hold timer; long pulse only on the final step.
          if (r_hold != HOLD_END) begin
            r_hold <= r_hold + 1'b1;
          end
          if (r_hold == HOLD_PRE) begin
            key_long <= 1'b1;
          end
          if (r_s2) begin
            r_state <= RELEASE_FILTER;
            r_cnt   <= '0;
          end
        end
        RELEASE_FILTER: begin
          // Bounce back keeps hold so the long-press timer resumes.
          if (!r_s2) begin
            r_state <= DOWN;
          end else if (r_cnt == CNT_END) begin
            r_state     <= IDLE;
            key_release <= 1'b1;
            key_state   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          key_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed self-checking bench for key_filter.
// DEB_MAX=8, LONG_MAX=40.
module tb_key_filter;

  logic clk;
  logic rst;
  logic key_in;
  logic key_flag;
  logic key_release;
  logic key_long;
  logic key_state;

  int n_chk;
  int n_pass;
  int nf, nr, nl, nlo;
  int last_ev;
  int alt_bad;

  key_filter #(
    .DEB_MAX (8),
    .LONG_MAX(40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_flag   (key_flag),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    nf = 0;
    nr = 0;
    nl = 0;
    nlo = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      nf = nf + int'(key_flag);
      nr = nr + int'(key_release);
      nl = nl + int'(key_long);
      if (!key_state) nlo = nlo + 1;
      if (key_flag) begin
        if (last_ev == 1) alt_bad = alt_bad + 1;
        last_ev = 1;
      end
      if (key_release) begin
        if (last_ev == 2) alt_bad = alt_bad + 1;
        last_ev = 2;
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    last_ev = 0;
    alt_bad = 0;
    clr();
    rst = 1'b1;
    key_in = 1'b1;
    #2;
    chk("rst_flag", int'(key_flag), 0);
    chk("rst_state", int'(key_state), 0);
    chk("rst_rel", int'(key_release), 0);
    chk("rst_long", int'(key_long), 0);
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("idle_state", int'(key_state), 0);

    // 1: clean press
    key_in = 1'b0;
    repeat (10) step();
    chk("t1_flag_early", int'(key_flag), 0);
    chk("t1_state_early", int'(key_state), 0);
    step();
    chk("t1_flag", int'(key_flag), 1);
    chk("t1_state", int'(key_state), 1);
    step();
    chk("t1_flag_1cyc", int'(key_flag), 0);
    chk("t1_state_hold", int'(key_state), 1);
    clr();
    run(28);
    chk("t1_no_long", nl, 0);
    chk("t1_no_reflag", nf, 0);
    chk("t1_state_kept", nlo, 0);
    key_in = 1'b1;
    repeat (10) step();
    chk("t1_rel_early", int'(key_release), 0);
    chk("t1_state_pre", int'(key_state), 1);
    step();
    chk("t1_rel", int'(key_release), 1);
    chk("t1_state_low", int'(key_state), 0);
    step();
    chk("t1_rel_1cyc", int'(key_release), 0);

    // 2: bounce rejection
    clr();
    for (int i = 0; i < 4; i++) begin
      key_in = 1'b0;
      run(5);
      key_in = 1'b1;
      run(2);
    end
    run(12);
    chk("t2_flag", nf, 0);
    chk("t2_rel", nr, 0);
    chk("t2_long", nl, 0);
    chk("t2_state", nlo, 40);

    // 3: long press
    key_in = 1'b0;
    repeat (11) step();
    chk("t3_flag", int'(key_flag), 1);
    repeat (39) step();
    chk("t3_long_early", int'(key_long), 0);
    step();
    chk("t3_long", int'(key_long), 1);
    step();
    chk("t3_long_1cyc", int'(key_long), 0);
    clr();
    run(28);
    chk("t3_no_long2", nl, 0);
    chk("t3_no_flag2", nf, 0);
    key_in = 1'b1;
    clr();
    run(12);
    chk("t3_rel", nr, 1);
    chk("t3_long_rel", nl, 0);
    chk("t3_state_end", int'(key_state), 0);

    // 4: release bounce
    key_in = 1'b0;
    repeat (11) step();
    chk("t4_flag", int'(key_flag), 1);
    clr();
    run(5);
    key_in = 1'b1;
    run(3);
    key_in = 1'b0;
    run(20);
    chk("t4_no_rel", nr, 0);
    chk("t4_state_kept", nlo, 0);
    chk("t4_no_flag", nf, 0);
    chk("t4_no_long", nl, 0);
    key_in = 1'b1;
    repeat (10) step();
    chk("t4_rel_early", int'(key_release), 0);
    step();
    chk("t4_rel", int'(key_release), 1);
    chk("t4_state_low", int'(key_state), 0);
    repeat (2) step();

    // 5: reset mid-press
    key_in = 1'b0;
    repeat (11) step();
    chk("t5_flag", int'(key_flag), 1);
    repeat (3) step();
    chk("t5_state_pre", int'(key_state), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_state", int'(key_state), 0);
    chk("t5_async_flag", int'(key_flag), 0);
    step();
    rst = 1'b0;
    repeat (10) step();
    chk("t5_reflag_early", int'(key_flag), 0);
    step();
    chk("t5_reflag", int'(key_flag), 1);
    chk("t5_restate", int'(key_state), 1);
    key_in = 1'b1;
    clr();
    run(12);
    chk("t5_rel", nr, 1);

    // 6: two presses
    clr();
    last_ev = 0;
    alt_bad = 0;
    key_in = 1'b0;
    run(20);
    key_in = 1'b1;
    run(12);
    key_in = 1'b0;
    run(20);
    key_in = 1'b1;
    run(15);
    chk("t6_flags", nf, 2);
    chk("t6_rels", nr, 2);
    chk("t6_alternate", alt_bad, 0);
    chk("t6_last_rel", last_ev, 2);
    chk("t6_state_end", int'(key_state), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
